// File: rtl/xor_fold_pipe.sv
// rtl/xor_fold_pipe.sv - pipelined per-channel XOR fold with optional frame accumulation
module xor_fold_pipe #(
    parameter int CH    = 2,
    parameter int W_OUT = 8,
    parameter int FOLD  = 2,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH*W_OUT*FOLD-1:0]  in_data,
    input  logic                      in_last,
    input  logic                      mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH*W_OUT-1:0]       out_data,
    output logic [CNT_W-1:0]          out_cnt,
    output logic                      frame_drop
);

    localparam int W_IN = W_OUT * FOLD;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CH*W_OUT-1:0] fold;
    logic [CH*W_OUT-1:0] acc;
    logic [CNT_W-1:0]    bc;
    logic [CNT_W-1:0]    bc_inc;
    logic                accept;
    logic                frame_active;

    // The single output register may be refilled in the same cycle it drains.
    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign frame_active = (bc != '0);
    assign bc_inc       = (bc == CNT_MAX) ? bc : bc + CNT_ONE;

    // XOR the FOLD segments of each channel down to one W_OUT-bit word.
    always_comb begin
        fold = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < FOLD; k++) begin
                fold[c*W_OUT +: W_OUT] = fold[c*W_OUT +: W_OUT]
                                       ^ in_data[c*W_IN + k*W_OUT +: W_OUT];
            end
        end
    end

    // Output stage, frame accumulator, beat counter and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_cnt    <= '0;
            frame_drop <= 1'b0;
            acc        <= '0;
            bc         <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (!mode) begin
                    // A per-beat fold arriving mid-frame abandons the partial frame.
                    out_valid <= 1'b1;
                    out_data  <= fold;
                    out_cnt   <= CNT_ONE;
                    if (frame_active) begin
                        acc        <= '0;
                        bc         <= '0;
                        frame_drop <= 1'b1;
                    end
                end else if (in_last) begin
                    out_valid <= 1'b1;
                    out_data  <= acc ^ fold;
                    out_cnt   <= bc_inc;
                    acc       <= '0;
                    bc        <= '0;
                end else begin
                    acc <= acc ^ fold;
                    bc  <= bc_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_fold_pipe.sv
// tb/tb_xor_fold_pipe.sv - directed self-checking bench for xor_fold_pipe
module tb_xor_fold_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        mode;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, frame_drop_a;
    logic [15:0] out_data_a;
    logic [7:0]  out_cnt_a;

    logic        in_ready_b, out_valid_b, frame_drop_b;
    logic [15:0] out_data_b;
    logic [1:0]  out_cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xor_fold_pipe #(.CH(2), .W_OUT(8), .FOLD(2), .CNT_W(8)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .in_data    (in_data),
        .in_last    (in_last),
        .mode       (mode),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_data   (out_data_a),
        .out_cnt    (out_cnt_a),
        .frame_drop (frame_drop_a)
    );

    xor_fold_pipe #(.CH(2), .W_OUT(8), .FOLD(2), .CNT_W(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .in_data    (in_data),
        .in_last    (in_last),
        .mode       (mode),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_data   (out_data_b),
        .out_cnt    (out_cnt_b),
        .frame_drop (frame_drop_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic l, input logic [31:0] d);
        in_valid = 1'b1;
        mode     = m;
        in_last  = l;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid_a), 32'h0);
        check("rst_out_data", 32'(out_data_a), 32'h0);
        check("rst_out_cnt", 32'(out_cnt_a), 32'h0);
        check("rst_frame_drop", 32'(frame_drop_a), 32'h0);
        check("rst_in_ready", 32'(in_ready_a), 32'h1);
        rst = 1'b0;
        tick();

        // mode 0 single beat
        beat(1'b0, 1'b0, 32'hAAAA12F0);
        tick();
        in_valid = 1'b0;
        check("m0_valid", 32'(out_valid_a), 32'h1);
        check("m0_data", 32'(out_data_a), 32'h00E2);
        check("m0_cnt", 32'(out_cnt_a), 32'h1);
        tick();
        check("m0_drain", 32'(out_valid_a), 32'h0);

        // mode 1 three-beat frame
        beat(1'b1, 1'b0, 32'h00010100);
        tick();
        check("m1_b0_novalid", 32'(out_valid_a), 32'h0);
        beat(1'b1, 1'b0, 32'h02030300);
        tick();
        check("m1_b1_novalid", 32'(out_valid_a), 32'h0);
        beat(1'b1, 1'b1, 32'h00000004);
        tick();
        in_valid = 1'b0;
        check("m1_valid", 32'(out_valid_a), 32'h1);
        check("m1_data", 32'(out_data_a), 32'h0006);
        check("m1_cnt", 32'(out_cnt_a), 32'h3);
        tick();
        check("m1_drain", 32'(out_valid_a), 32'h0);

        // backpressure: result held, next beat waits, then accepted without a gap
        out_ready = 1'b0;
        beat(1'b0, 1'b0, 32'h00001234);
        tick();
        beat(1'b0, 1'b0, 32'h00005600);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(in_ready_a), 32'h0);
            check("bp_data_hold", 32'(out_data_a), 32'h0026);
            check("bp_valid_hold", 32'(out_valid_a), 32'h1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready_a), 32'h1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid_a), 32'h1);
        check("bp_next_data", 32'(out_data_a), 32'h0056);
        tick();
        check("bp_drain", 32'(out_valid_a), 32'h0);

        // mode 0 beat interrupting a frame
        beat(1'b1, 1'b0, 32'h00010100);
        tick();
        beat(1'b1, 1'b0, 32'h02030300);
        tick();
        beat(1'b0, 1'b1, 32'h0000FF00);
        tick();
        check("drop_data", 32'(out_data_a), 32'h00FF);
        check("drop_cnt", 32'(out_cnt_a), 32'h1);
        check("drop_flag", 32'(frame_drop_a), 32'h1);
        beat(1'b1, 1'b1, 32'h00000004);
        tick();
        in_valid = 1'b0;
        check("after_drop_data", 32'(out_data_a), 32'h0004);
        check("after_drop_cnt", 32'(out_cnt_a), 32'h1);
        check("drop_sticky", 32'(frame_drop_a), 32'h1);
        tick();

        // five-beat frame: CNT_W=8 counts 5, CNT_W=2 saturates at 3
        beat(1'b1, 1'b0, 32'h00000001);
        tick();
        beat(1'b1, 1'b0, 32'h00000002);
        tick();
        beat(1'b1, 1'b0, 32'h00000004);
        tick();
        beat(1'b1, 1'b0, 32'h00000008);
        tick();
        check("sat_novalid", 32'(out_valid_b), 32'h0);
        beat(1'b1, 1'b1, 32'h00000010);
        tick();
        in_valid = 1'b0;
        check("sat_a_data", 32'(out_data_a), 32'h001F);
        check("sat_a_cnt", 32'(out_cnt_a), 32'h5);
        check("sat_b_valid", 32'(out_valid_b), 32'h1);
        check("sat_b_data", 32'(out_data_b), 32'h001F);
        check("sat_b_cnt", 32'(out_cnt_b), 32'h3);
        check("sat_b_drop", 32'(frame_drop_b), 32'h1);
        check("sat_b_in_ready", 32'(in_ready_b), 32'h1);
        tick();

        // reset mid-frame, with a simultaneous beat that must be ignored
        beat(1'b1, 1'b0, 32'h00010100);
        tick();
        beat(1'b1, 1'b0, 32'h02030300);
        tick();
        rst = 1'b1;
        beat(1'b0, 1'b0, 32'hAAAA12F0);
        tick();
        in_valid = 1'b0;
        check("rst2_valid", 32'(out_valid_a), 32'h0);
        check("rst2_data", 32'(out_data_a), 32'h0);
        check("rst2_cnt", 32'(out_cnt_a), 32'h0);
        check("rst2_drop", 32'(frame_drop_a), 32'h0);
        rst = 1'b0;
        tick();
        beat(1'b1, 1'b1, 32'h00000101);
        tick();
        in_valid = 1'b0;
        check("fresh_valid", 32'(out_valid_a), 32'h1);
        check("fresh_data", 32'(out_data_a), 32'h0000);
        check("fresh_cnt", 32'(out_cnt_a), 32'h1);
        check("fresh_drop", 32'(frame_drop_a), 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xor_fold_pipe.md
Name: xor_fold_pipe

Overview:
Parametrised, pipelined XOR folding unit for the datapath hashing/compaction layer. Each of CH channels folds a W_OUT*FOLD-bit word down to W_OUT bits by XOR-ing its FOLD segments. Mode 1 also XOR-accumulates folded values across a multi-beat frame. Valid/ready handshakes on both sides; one registered output stage.

Parameters:
CH, 2, number of independent channels
W_OUT, 8, folded output width per channel
FOLD, 2, segments per input word; W_IN = W_OUT*FOLD per channel; must be >= 1
CNT_W, 8, width of the beat counter reported with each result

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat this cycle
in_data  input  CH*W_OUT*FOLD  packed channels; channel c = bits [c*W_IN +: W_IN]
in_last  input  1  last beat of frame (used in mode 1 only)
mode  input  1  0 = per-beat fold, 1 = frame accumulate; sampled with each accepted beat
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  CH*W_OUT  packed folded results; channel c = bits [c*W_OUT +: W_OUT]
out_cnt  output  CNT_W  beats contributing to this result (saturating)
frame_drop  output  1  sticky: an accumulation frame was discarded

Behaviour:
- Fold: f[c] = XOR over k=0..FOLD-1 of in_data[c*W_IN + k*W_OUT +: W_OUT]. FOLD=1 is pass-through.
- Accept: beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational). Full throughput: one beat per cycle under continuous out_ready.
- Mode 0 beat: cycle after acceptance, out_valid=1, out_data=f, out_cnt=1.
- Mode 1 beat, in_last=0: acc[c] <= acc[c]^f[c]; beat count bc <= sat(bc+1). No output.
- Mode 1 beat, in_last=1: cycle after acceptance, out_valid=1, out_data=acc^f, out_cnt=sat(bc+1). acc and bc cleared in the same edge.
- A frame is in progress when bc != 0.
- Mode 0 beat while a frame is in progress: emit the beat's own fold (out_cnt=1). Clear acc and bc. Set frame_drop=1. frame_drop stays set until rst.
- Saturation: bc and out_cnt stop at 2^CNT_W-1. Accumulation continues after saturation.
- Output hold: while out_valid && !out_ready, out_data and out_cnt stay stable and in_ready=0. A new beat is accepted in the same cycle the current result is consumed (out_ready=1).
- Mode 1 non-last beats also require in_ready. No beat bypasses the stall.
- out_valid drops the cycle after consumption if no new result-producing beat was accepted.
- Latency: 1 cycle from acceptance of a producing beat to out_valid.
- Reset: out_valid=0, out_data=0, out_cnt=0, frame_drop=0, acc=0, bc=0. Reset mid-frame discards the partial frame without setting frame_drop. Reset overrides a simultaneous accept.
- in_last is ignored in mode 0.

Test Plan:
- Mode 0, CH=2/W_OUT=8/FOLD=2, in_data=32'hAAAA12F0 -> next cycle out_valid=1, out_data=16'h00E2, out_cnt=1.
- Mode 1 frame of 32'h00010100, 32'h02030300, then 32'h00000004 with last=1 -> one result, out_data=16'h0006, out_cnt=3. No out_valid on the first two beats.
- Backpressure: result pending with out_ready=0 for 3 cycles -> in_ready=0, out_data constant. Raise out_ready with in_valid high -> beat accepted same cycle, next result next cycle, no gap.
- Mode 1 two beats, then a mode 0 beat 32'h0000FF00 -> out_data=16'h00FF, out_cnt=1, frame_drop=1. A following mode 1 single-beat frame starts from acc=0.
- CNT_W=2, mode 1 frame of 5 beats -> out_cnt=3 (saturated), out_data equals the XOR of all 5 folds.
- rst asserted after 2 mode 1 beats -> all outputs 0, frame_drop=0. A fresh 1-beat frame 32'h00000101 -> out_data=16'h0000, out_cnt=1.
